// File: rtl/tick_prescaler.sv
// Timebase generator: divides mclk to a one-cycle tick and drives a cascaded modulo-MOD counter.
// Define TICK_DIV_LOAD_EN to enable the runtime divisor load through div_load/div_value.
module tick_prescaler #(
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 1,
    parameter int MOD     = 60,
    localparam int DIV    = CLK_HZ / TICK_HZ,
    localparam int PW     = $clog2(DIV + 1),
    localparam int SW     = $clog2(MOD)
) (
    input  logic          mclk,
    input  logic          reset,
    input  logic          en,
    input  logic          clr,
    input  logic          div_load,
    input  logic [PW-1:0] div_value,
    output logic          tick,
    output logic [PW-1:0] pre_cnt,
    output logic [SW-1:0] sec_cnt,
    output logic          carry
);

    logic [PW-1:0] r_pre;
    logic [SW-1:0] r_sec;
    logic          r_tick;
    logic          r_carry;
    logic [PW-1:0] w_div;
    logic          w_load_ok;
    logic          w_pre_tc;
    logic          w_sec_tc;

`ifdef TICK_DIV_LOAD_EN
    logic [PW-1:0] r_div;

    // Divisors below 2 cannot produce a one-cycle tick, so they are dropped.
    assign w_load_ok = div_load && (div_value >= PW'(2));

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            r_div <= PW'(DIV);
        end else if (w_load_ok) begin
            r_div <= div_value;
        end
    end

    assign w_div = r_div;
`else
    assign w_load_ok = 1'b0;
    assign w_div     = PW'(DIV);

    logic w_unused;
    assign w_unused = &{1'b0, div_load, div_value};
`endif

    assign w_pre_tc = (r_pre == (w_div - PW'(1)));
    assign w_sec_tc = (r_sec == SW'(MOD - 1));

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            r_pre   <= '0;
            r_sec   <= '0;
            r_tick  <= 1'b0;
            r_carry <= 1'b0;
        end else if (clr || w_load_ok) begin
            r_pre   <= '0;
            r_tick  <= 1'b0;
            r_carry <= 1'b0;
            if (clr) begin
                r_sec <= '0;
            end
        end else if (!en) begin
            // A terminal count reached while disabled is held until en returns.
            r_tick  <= 1'b0;
            r_carry <= 1'b0;
        end else if (w_pre_tc) begin
            r_pre  <= '0;
            r_tick <= 1'b1;
            if (w_sec_tc) begin
                r_sec   <= '0;
                r_carry <= 1'b1;
            end else begin
                r_sec   <= r_sec + SW'(1);
                r_carry <= 1'b0;
            end
        end else begin
            r_pre   <= r_pre + PW'(1);
            r_tick  <= 1'b0;
            r_carry <= 1'b0;
        end
    end

    assign tick    = r_tick;
    assign pre_cnt = r_pre;
    assign sec_cnt = r_sec;
    assign carry   = r_carry;

endmodule

// File: tb/tb_tick_prescaler.sv
// Directed self-checking bench for tick_prescaler with DIV = 10, MOD = 3.
// Expected load behaviour follows TICK_DIV_LOAD_EN as seen by this compilation.
module tb_tick_prescaler;

    localparam int PW = 4;
    localparam int SW = 2;

`ifdef TICK_DIV_LOAD_EN
    localparam int P4       = 4;
    localparam int P8       = 8;
    localparam int LOAD_PRE = 0;
`else
    localparam int P4       = 10;
    localparam int P8       = 10;
    localparam int LOAD_PRE = 1;
`endif

    logic          mclk;
    logic          reset;
    logic          en;
    logic          clr;
    logic          div_load;
    logic [PW-1:0] div_value;
    logic          tick;
    logic [PW-1:0] pre_cnt;
    logic [SW-1:0] sec_cnt;
    logic          carry;

    int checks = 0;
    int errors = 0;
    int n;

    tick_prescaler #(.CLK_HZ(10), .TICK_HZ(1), .MOD(3)) dut (
        .mclk      (mclk),
        .reset     (reset),
        .en        (en),
        .clr       (clr),
        .div_load  (div_load),
        .div_value (div_value),
        .tick      (tick),
        .pre_cnt   (pre_cnt),
        .sec_cnt   (sec_cnt),
        .carry     (carry)
    );

    initial begin
        mclk = 1'b0;
        forever #5 mclk = ~mclk;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int k);
        repeat (k) @(posedge mclk);
        #1;
    endtask

    // Edges until tick is seen high; 40 means it never came.
    task automatic wait_tick(output int cnt);
        cnt = 0;
        do begin
            @(posedge mclk);
            #1;
            cnt++;
        end while (!tick && cnt < 40);
    endtask

    initial begin
        reset     = 1'b0;
        en        = 1'b1;
        clr       = 1'b0;
        div_load  = 1'b0;
        div_value = '0;
        #1 reset = 1'b1;
        #2;
        chk("rst_pre", pre_cnt, 0);
        chk("rst_sec", sec_cnt, 0);
        chk("rst_tick", tick, 0);
        chk("rst_carry", carry, 0);
        @(posedge mclk);
        #1 reset = 1'b0;

        // Free run: ticks after edges 10, 20, 30
        step(9);
        chk("pre_before_tc", pre_cnt, 9);
        chk("no_tick_early", tick, 0);
        step(1);
        chk("tick1", tick, 1);
        chk("sec1", sec_cnt, 1);
        chk("carry1", carry, 0);
        chk("pre_wrap", pre_cnt, 0);
        wait_tick(n);
        chk("period2", n, 10);
        chk("sec2", sec_cnt, 2);
        chk("carry2", carry, 0);
        wait_tick(n);
        chk("period3", n, 10);
        chk("sec3", sec_cnt, 0);
        chk("carry3", carry, 1);
        step(1);
        chk("tick_width", tick, 0);
        chk("carry_width", carry, 0);
        chk("pre_after", pre_cnt, 1);

        // Enable low for 5 cycles at pre_cnt = 4
        step(3);
        chk("pre_at4", pre_cnt, 4);
        en = 1'b0;
        step(5);
        chk("pre_hold", pre_cnt, 4);
        chk("no_tick_en0", tick, 0);
        en = 1'b1;
        wait_tick(n);
        chk("period_stretch", n, 6);
        chk("sec_stretch", sec_cnt, 1);

        // Clear at pre_cnt = 7, sec_cnt = 2
        wait_tick(n);
        chk("period_pre_clr", n, 10);
        chk("sec_pre_clr", sec_cnt, 2);
        step(7);
        chk("pre_at7", pre_cnt, 7);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        chk("clr_pre", pre_cnt, 0);
        chk("clr_sec", sec_cnt, 0);
        wait_tick(n);
        chk("period_after_clr", n, 10);
        chk("sec_after_clr", sec_cnt, 1);

        // Clear on a terminal-count cycle suppresses the tick
        step(9);
        chk("pre_tc", pre_cnt, 9);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        chk("clr_tc_tick", tick, 0);
        chk("clr_tc_pre", pre_cnt, 0);
        chk("clr_tc_sec", sec_cnt, 0);
        wait_tick(n);
        chk("period_after_clr_tc", n, 10);
        chk("sec_after_clr_tc", sec_cnt, 1);

        // Terminal count held while en is low
        step(9);
        en = 1'b0;
        step(3);
        chk("tc_hold_pre", pre_cnt, 9);
        chk("tc_hold_tick", tick, 0);
        en = 1'b1;
        step(1);
        chk("tc_release_tick", tick, 1);
        chk("tc_release_sec", sec_cnt, 2);

        // Divisor load of 4, then invalid load of 1
        div_load  = 1'b1;
        div_value = 4'd4;
        step(1);
        div_load  = 1'b0;
        chk("load_pre", pre_cnt, LOAD_PRE);
        chk("load_sec_hold", sec_cnt, 2);
        chk("load_tick", tick, 0);
        wait_tick(n);
        chk("load_period1", n, P4 - LOAD_PRE);
        chk("load_sec_wrap", sec_cnt, 0);
        chk("load_carry", carry, 1);
        wait_tick(n);
        chk("load_period2", n, P4);
        chk("load_sec1", sec_cnt, 1);
        div_load  = 1'b1;
        div_value = 4'd1;
        step(1);
        div_load  = 1'b0;
        chk("bad_load_pre", pre_cnt, 1);
        wait_tick(n);
        chk("bad_load_rest", n, P4 - 1);
        chk("bad_load_sec", sec_cnt, 2);
        wait_tick(n);
        chk("bad_load_period", n, P4);
        chk("bad_load_carry", carry, 1);

        // Clear together with a load of 8
        clr       = 1'b1;
        div_load  = 1'b1;
        div_value = 4'd8;
        step(1);
        clr      = 1'b0;
        div_load = 1'b0;
        chk("clrload_pre", pre_cnt, 0);
        chk("clrload_sec", sec_cnt, 0);
        wait_tick(n);
        chk("clrload_period", n, P8);
        chk("clrload_sec1", sec_cnt, 1);

        // Asynchronous reset between edges at pre_cnt = 6, sec_cnt = 1
        step(6);
        chk("pre_at6", pre_cnt, 6);
        #2 reset = 1'b1;
        #1;
        chk("arst_pre", pre_cnt, 0);
        chk("arst_sec", sec_cnt, 0);
        chk("arst_tick", tick, 0);
        chk("arst_carry", carry, 0);
        reset = 1'b0;
        wait_tick(n);
        chk("period_after_rst", n, 10);
        chk("sec_after_rst", sec_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tick_prescaler.md
# tick_prescaler

Parametrised timebase generator for the clock datapath. It divides the master clock down to a one-cycle `tick` at `TICK_HZ` and feeds a cascaded modulo-`MOD` counter (e.g. seconds 0–59) with its own one-cycle `carry`. It adds enable, synchronous clear and an optional runtime divisor load. The tick period is exactly `DIV` clock cycles; there is no N+1 off-by-one.

## Interface
Parameters:
- `CLK_HZ`, 50000000, master clock frequency in Hz.
- `TICK_HZ`, 1, tick rate in Hz. `DIV = CLK_HZ/TICK_HZ`; `CLK_HZ` must be an exact multiple of `TICK_HZ`, and `DIV >= 2`.
- `MOD`, 60, modulus of the cascaded counter; `MOD >= 2`.
- Derived widths: `PW = $clog2(DIV+1)` and `SW = $clog2(MOD)`, both localparams.

Ports:
- `mclk`  in  1  master clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `en`  in  1  count enable.
- `clr`  in  1  synchronous clear of the counters.
- `div_load`  in  1  load strobe for `div_value`.
- `div_value`  in  PW  new divisor, in cycles.
- `tick`  out  1  registered one-cycle pulse, once per divisor period.
- `pre_cnt`  out  PW  prescaler count, range 0..div_reg-1.
- `sec_cnt`  out  SW  cascaded count, range 0..MOD-1.
- `carry`  out  1  registered one-cycle pulse when `sec_cnt` wraps.

## Operation
- Internal state: `div_reg` (PW), `pre_cnt`, `sec_cnt`, `tick`, `carry`.
- Per-edge priority: `reset` > `clr`/`div_load` > counting.
- `reset` high forces the following immediately, with no clock edge needed:
  - `pre_cnt = 0`, `sec_cnt = 0`, `tick = 0`, `carry = 0`;
  - `div_reg = DIV`.
- `clr = 1`:
  - `pre_cnt` and `sec_cnt` go to 0; `tick` and `carry` go to 0.
  - `div_reg` is unchanged unless `div_load` is also high; in that case both actions apply.
- `div_load = 1` with `TICK_DIV_LOAD_EN` defined and `div_value >= 2`:
  - `div_reg <= div_value`, `pre_cnt <= 0`, `tick <= 0`, `carry <= 0`; `sec_cnt` holds.
- `div_load = 1` with `div_value < 2`: the load is ignored and normal counting continues that cycle.
- Counting (no clr, no valid load):
  - `en = 0`: `pre_cnt` and `sec_cnt` hold; `tick <= 0`, `carry <= 0`.
  - `en = 1` and `pre_cnt != div_reg-1`: `pre_cnt <= pre_cnt+1`, `tick <= 0`, `carry <= 0`.
  - `en = 1` and `pre_cnt == div_reg-1` (terminal count): `pre_cnt <= 0`, `tick <= 1`.
    - If `sec_cnt == MOD-1`: `sec_cnt <= 0` and `carry <= 1`.
    - Otherwise: `sec_cnt <= sec_cnt+1` and `carry <= 0`.
- `carry` is only ever high together with `tick`.
- All arithmetic is unsigned and wrap-free: counters are compared to their terminal value and never overflow their width.

## Timing
- With `en` held high from the first edge after `reset` falls, `tick` is high in the cycle following the DIV-th rising edge, then every `div_reg` edges after that.
- `tick` and `carry` are each exactly one `mclk` cycle wide.
- Latency from terminal count to `tick` high is one edge; `sec_cnt` updates on that same edge.
- Dropping `en` stretches the period by exactly the number of cycles `en` is low. A terminal count reached while `en` is low is held until `en` returns.
- `clr` or a load asserted on a terminal-count cycle suppresses that tick.
- A new divisor takes effect from `pre_cnt = 0`; the next tick follows `div_value` enabled edges later.
- Asserting `reset` mid-operation clears outputs asynchronously. Release of `reset` is assumed synchronised upstream.

## Configuration
- Macro: `TICK_DIV_LOAD_EN`.
- Defined: `div_load`/`div_value` behave as described above.
- Undefined:
  - `div_reg` is the constant `DIV`.
  - `div_load` and `div_value` stay on the port list but are ignored.
  - No load logic is synthesised.

## Test plan
All scenarios use `CLK_HZ = 10`, `TICK_HZ = 1` (so `DIV = 10`) and `MOD = 3`.
- Reset released, `en = 1`:
  - `tick` high after edges 10, 20, 30;
  - `sec_cnt` goes 1, 2, 0;
  - `carry` high only with the third tick.
- `en = 0` for 5 cycles at `pre_cnt = 4`: `pre_cnt` holds at 4; the next tick arrives after edge 15 instead of edge 10.
- `clr` pulsed at `pre_cnt = 7`, `sec_cnt = 2`:
  - next cycle `pre_cnt = 0`, `sec_cnt = 0`;
  - next tick arrives 10 edges later;
  - `clr` on a terminal-count cycle produces no tick.
- With the macro defined:
  - load `div_value = 4`: ticks every 4 edges;
  - load `div_value = 1`: ignored, period stays 4.
- Without the macro: load `div_value = 4`; the period stays 10.
- `reset` raised asynchronously between edges at `pre_cnt = 6`, `sec_cnt = 1`:
  - all outputs 0 before the next edge;
  - after release, the first tick comes after edge 10 (`div_reg` restored).
